// File: rtl/addsub_seq.sv
// addsub_seq: command sequencer for the 16-bit add/sub datapath.
// Accepts one command at a time on a valid/ready port, drives the datapath
// operand/select inputs and holds them steady, waits a fixed pipeline
// latency, captures the datapath result and offers it on a valid/ready
// response port. Every output is a flop; nothing passes combinationally
// from an input to an output.
module addsub_seq #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  // command port
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [WIDTH-1:0] cmd_data_i,
  // datapath side
  output logic [WIDTH-1:0] dp_in_o,
  output logic             dp_sel_12_o,
  output logic             dp_sel_3_o,
  input  logic [WIDTH-1:0] dp_out_i,
  // response port
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_data_o,
  // status
  output logic             busy_o,
  output logic [7:0]       done_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Counter value loaded on acceptance; the result is sampled on the edge
  // where the counter has reached zero, i.e. LATENCY+1 edges after accept.
  localparam logic [3:0] WAIT_INIT = 4'(LATENCY);

  state_e           state_q;
  logic [3:0]       wait_cnt_q;
  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic             busy_q;
  logic [WIDTH-1:0] dp_in_q;
  logic             dp_sel_12_q;
  logic             dp_sel_3_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [7:0]       done_count_q;

  // Sequencer FSM with all outputs held in flops alongside the state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= 4'd0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      dp_in_q      <= '0;
      dp_sel_12_q  <= 1'b0;
      dp_sel_3_q   <= 1'b0;
      rsp_data_q   <= '0;
      done_count_q <= 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Datapath inputs only ever move here, so they never glitch
          // while an operation is in flight.
          if (cmd_valid_i && cmd_ready_q) begin
            dp_in_q     <= cmd_data_i;
            dp_sel_12_q <= cmd_op_i[1];
            dp_sel_3_q  <= cmd_op_i[0];
            wait_cnt_q  <= WAIT_INIT;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_WAIT;
          end else begin
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_q != 4'd0) begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end else begin
            // Result passes through untouched; wrap happens in the datapath.
            rsp_data_q  <= dp_out_i;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          // rsp_data_q is not written here, so it stays stable under
          // arbitrarily long backpressure.
          if (rsp_ready_i) begin
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            cmd_ready_q  <= 1'b1;
            done_count_q <= done_count_q + 8'd1;
            state_q      <= ST_IDLE;
          end else begin
            rsp_valid_q <= 1'b1;
          end
        end
        default: begin
          // Recover from an illegal encoding into a clean idle state.
          state_q     <= ST_IDLE;
          wait_cnt_q  <= 4'd0;
          cmd_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign busy_o       = busy_q;
  assign dp_in_o      = dp_in_q;
  assign dp_sel_12_o  = dp_sel_12_q;
  assign dp_sel_3_o   = dp_sel_3_q;
  assign rsp_data_o   = rsp_data_q;
  assign done_count_o = done_count_q;

endmodule
